// File: rtl/pipe_pkg.sv
// Shared types and default sizing for the Flappy Bird pipe-field scroller.
package pipe_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FROZEN
   } state_t;

   localparam int ROWS_DEF = 8;
   localparam int COLS_DEF = 16;
   localparam int SLOW_DEF = 256;
   localparam int FAST_DEF = 128;
   localparam int GAP_DEF  = 3;
   localparam int BIRD_DEF = 1;

endpackage

// File: rtl/pipe_scroller_tick_gen.sv
// Scroll-tick divider with a slow/fast period select.
module tick_gen
   import pipe_pkg::*;
#(
   parameter int SLOW_DIV = SLOW_DEF,
   parameter int FAST_DIV = FAST_DEF
) (
   input  logic clk,
   input  logic clr,
   input  logic run,
   input  logic fast,
   output logic tick
);

   localparam int CW = $clog2(SLOW_DIV);
   localparam logic [CW:0] SLOW_TOP = (CW + 1)'(SLOW_DIV - 1);
   localparam logic [CW:0] FAST_TOP = (CW + 1)'(FAST_DIV - 1);

   logic [CW-1:0] div_cnt;
   logic [CW:0]   top_val;

   assign top_val = fast ? FAST_TOP : SLOW_TOP;
   assign tick    = run & (div_cnt == '0);

   // Out-of-range counts after a switch to fast wrap straight to zero.
   always_ff @(posedge clk) begin
      if (clr) begin
         div_cnt <= '0;
      end else if (run) begin
         if ({1'b0, div_cnt} >= top_val) div_cnt <= '0;
         else div_cnt <= div_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/pipe_scroller.sv
// Pipe-field scroller: shifts pipe columns left, inserts gaps,
// and reports collisions and scores at the bird column.
module pipe_scroller
   import pipe_pkg::*;
#(
   parameter int ROWS     = ROWS_DEF,
   parameter int COLS     = COLS_DEF,
   parameter int SLOW_DIV = SLOW_DEF,
   parameter int FAST_DIV = FAST_DEF,
   parameter int GAP      = GAP_DEF,
   parameter int BIRD_COL = BIRD_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 active,
   input  logic                 gameover,
   input  logic                 fast,
   input  logic                 pat_valid,
   input  logic [ROWS-1:0]      new_pattern,
   output logic                 pat_ready,
   input  logic [ROWS-1:0]      bird_row,
   output logic [COLS*ROWS-1:0] frame,
   output logic                 collide,
   output logic                 score_pulse
);

   localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
   localparam logic [GW-1:0] GAP_LD = GW'(GAP);

   state_t          state;
   logic            tick;
   logic            take;
   logic [GW-1:0]   gap_cnt;
   logic [ROWS-1:0] col [COLS];
   logic [ROWS-1:0] entry;
   logic [ROWS-1:0] bird_col;

   // Mode follows the controls directly so a freeze or clear acts in-cycle.
   always_comb begin
      state = IDLE;
      if (reset & active) state = gameover ? FROZEN : RUN;
   end

   tick_gen #(
      .SLOW_DIV(SLOW_DIV),
      .FAST_DIV(FAST_DIV)
   ) u_tick (
      .clk (clk),
      .clr (state == IDLE),
      .run (state == RUN),
      .fast(fast),
      .tick(tick)
   );

   assign pat_ready = tick & (gap_cnt == '0);
   assign take      = pat_ready & pat_valid;
   assign entry     = take ? new_pattern : '0;
   assign bird_col  = col[BIRD_COL];
   assign collide   = (state != IDLE) & (|(bird_col & bird_row));

   always_ff @(posedge clk) begin
      if (state == IDLE) begin
         for (int c = 0; c < COLS; c++) col[c] <= '0;
         gap_cnt     <= '0;
         score_pulse <= 1'b0;
      end else begin
         score_pulse <= tick & (|bird_col) & ~collide;
         if (tick) begin
            for (int c = 0; c < COLS - 1; c++) col[c] <= col[c+1];
            col[COLS-1] <= entry;
            if (take) gap_cnt <= GAP_LD;
            else if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
         end
      end
   end

   for (genvar c = 0; c < COLS; c++) begin : g_frame
      assign frame[c*ROWS +: ROWS] = col[c];
   end

endmodule

// File: tb/tb_pipe_scroller.sv
// Scenario and randomized checks of pipe_scroller against a frame-level model.
module tb_pipe_scroller;

   localparam int ROWS = 8;
   localparam int COLS = 16;
   localparam int SLOW = 256;
   localparam int FAST = 128;
   localparam int GAP  = 3;
   localparam int BIRD = 1;

   logic clk, reset, active, gameover, fast, pat_valid;
   logic [ROWS-1:0] new_pattern, bird_row;
   logic pat_ready, collide, score_pulse;
   logic [COLS*ROWS-1:0] frame;

   int n_checks = 0;
   int n_fail = 0;

   // reference model state
   logic [COLS*ROWS-1:0] m_frame = '0;
   int m_cnt = 0;
   int m_gap = 0;
   bit m_score = 0;

   pipe_scroller dut (
      .clk(clk), .reset(reset), .active(active), .gameover(gameover),
      .fast(fast), .pat_valid(pat_valid), .new_pattern(new_pattern),
      .pat_ready(pat_ready), .bird_row(bird_row), .frame(frame),
      .collide(collide), .score_pulse(score_pulse)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   function automatic bit m_tick();
      return reset && active && !gameover && m_cnt == 0;
   endfunction

   function automatic bit m_ready();
      return m_tick() && m_gap == 0;
   endfunction

   function automatic bit m_collide();
      logic [ROWS-1:0] bc;
      bc = m_frame[BIRD*ROWS +: ROWS];
      return reset && active && ((bc & bird_row) != 0);
   endfunction

   task automatic step();
      bit tk, hit;
      logic [ROWS-1:0] bc, ent;
      int div;
      tk = m_tick();
      hit = m_collide();
      bc = m_frame[BIRD*ROWS +: ROWS];
      if (!(reset && active)) begin
         m_frame = '0; m_cnt = 0; m_gap = 0; m_score = 0;
      end else begin
         m_score = tk && bc != 0 && !hit;
         if (tk) begin
            ent = (m_gap == 0 && pat_valid) ? new_pattern : '0;
            if (m_gap > 0) m_gap--;
            else if (pat_valid) m_gap = GAP;
            m_frame = m_frame >> ROWS;
            m_frame[(COLS-1)*ROWS +: ROWS] = ent;
         end
         if (!gameover) begin
            div = fast ? FAST : SLOW;
            m_cnt = (m_cnt + 1 >= div) ? 0 : m_cnt + 1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_tick(string tag);
      int n = 0;
      while (!m_tick() && n < 400) begin
         step();
         n++;
      end
      if (!m_tick()) begin
         n_checks++; n_fail++;
         $display("FAIL %s: no tick after %0d cycles, want <400", tag, n);
      end
   endtask

   task automatic test_reset();
      reset = 0; active = 0; gameover = 0; fast = 0;
      pat_valid = 0; new_pattern = '0; bird_row = 8'hFF;
      step(); step();
      n_checks++;
      if (frame !== '0) begin
         n_fail++; $display("FAIL rst_frame: got %h want 0", frame);
      end
      n_checks++;
      if (pat_ready !== 1'b0) begin
         n_fail++; $display("FAIL rst_ready: got %b want 0", pat_ready);
      end
      n_checks++;
      if (collide !== 1'b0 || score_pulse !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_flags: got %b%b want 00", collide, score_pulse);
      end
      n_checks++;
      if (dut.u_tick.div_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL rst_div: got %0d want 0", dut.u_tick.div_cnt);
      end
   endtask

   task automatic test_first_pipe();
      reset = 1; active = 1; pat_valid = 1;
      new_pattern = 8'b10100110; bird_row = 8'b00000001;
      #1;
      n_checks++;
      if (pat_ready !== 1'b1) begin
         n_fail++; $display("FAIL first_ready: got %b want 1", pat_ready);
      end
      step();
      n_checks++;
      if (frame[15*ROWS +: ROWS] !== 8'b10100110) begin
         n_fail++;
         $display("FAIL first_col15: got %b want 10100110",
                  frame[15*ROWS +: ROWS]);
      end
      new_pattern = 8'hFF;
      for (int k = 0; k < 3; k++) begin
         wait_tick("gap_tick");
         n_checks++;
         if (pat_ready !== 1'b0) begin
            n_fail++; $display("FAIL gap_ready%0d: got %b want 0", k, pat_ready);
         end
         step();
         n_checks++;
         if (frame[15*ROWS +: ROWS] !== 8'h00 ||
             frame[(14-k)*ROWS +: ROWS] !== 8'b10100110) begin
            n_fail++;
            $display("FAIL gap_shift%0d: got %h want pipe at col %0d",
                     k, frame, 14 - k);
         end
      end
      wait_tick("after_gap");
      n_checks++;
      if (pat_ready !== 1'b1) begin
         n_fail++; $display("FAIL after_gap_ready: got %b want 1", pat_ready);
      end
      step();
      n_checks++;
      if (frame[15*ROWS +: ROWS] !== 8'hFF ||
          frame[11*ROWS +: ROWS] !== 8'b10100110) begin
         n_fail++; $display("FAIL second_pipe: got %h", frame);
      end
   endtask

   task automatic test_no_valid();
      fast = 1;
      while (m_gap != 0) begin
         wait_tick("drain");
         step();
      end
      wait_tick("novalid");
      pat_valid = 0;
      #1;
      n_checks++;
      if (pat_ready !== 1'b1) begin
         n_fail++; $display("FAIL novalid_ready: got %b want 1", pat_ready);
      end
      step();
      n_checks++;
      if (frame[15*ROWS +: ROWS] !== 8'h00) begin
         n_fail++;
         $display("FAIL novalid_col15: got %b want 0", frame[15*ROWS +: ROWS]);
      end
      wait_tick("retry");
      pat_valid = 1; new_pattern = 8'b11010101;
      #1;
      n_checks++;
      if (pat_ready !== 1'b1) begin
         n_fail++; $display("FAIL retry_ready: got %b want 1", pat_ready);
      end
      step();
      n_checks++;
      if (frame[15*ROWS +: ROWS] !== 8'b11010101 ||
          frame[14*ROWS +: ROWS] !== 8'h00) begin
         n_fail++;
         $display("FAIL retry_cols: got %b %b want 11010101 00000000",
                  frame[15*ROWS +: ROWS], frame[14*ROWS +: ROWS]);
      end
   endtask

   task automatic test_collide_freeze();
      logic [COLS*ROWS-1:0] exp;
      int dc0;
      bit bad_ready = 0;
      active = 0;
      step();
      active = 1; pat_valid = 1; new_pattern = 8'b11110000;
      bird_row = 8'b00000001;
      step();
      pat_valid = 0;
      repeat (14) begin
         wait_tick("to_bird");
         step();
      end
      exp = '0;
      exp[1*ROWS +: ROWS] = 8'b11110000;
      n_checks++;
      if (frame !== exp) begin
         n_fail++; $display("FAIL at_bird: got %h want %h", frame, exp);
      end
      bird_row = 8'b00010000;
      #1;
      n_checks++;
      if (collide !== 1'b1) begin
         n_fail++; $display("FAIL collide_hit: got %b want 1", collide);
      end
      gameover = 1;
      dc0 = m_cnt;
      repeat (500) begin
         step();
         if (pat_ready !== 1'b0) bad_ready = 1;
      end
      n_checks++;
      if (bad_ready) begin
         n_fail++; $display("FAIL frozen_ready: got 1 want 0");
      end
      n_checks++;
      if (frame !== exp || int'(dut.u_tick.div_cnt) != dc0) begin
         n_fail++;
         $display("FAIL frozen_hold: got %h/%0d want %h/%0d",
                  frame, dut.u_tick.div_cnt, exp, dc0);
      end
      n_checks++;
      if (collide !== 1'b1) begin
         n_fail++; $display("FAIL frozen_collide: got %b want 1", collide);
      end
      gameover = 0;
   endtask

   task automatic test_score();
      bird_row = 8'b00001000;
      #1;
      n_checks++;
      if (collide !== 1'b0) begin
         n_fail++; $display("FAIL collide_miss: got %b want 0", collide);
      end
      wait_tick("score");
      step();
      n_checks++;
      if (score_pulse !== 1'b1 || frame[0 +: ROWS] !== 8'b11110000) begin
         n_fail++;
         $display("FAIL score_hi: got %b/%b want 1/11110000",
                  score_pulse, frame[0 +: ROWS]);
      end
      step();
      n_checks++;
      if (score_pulse !== 1'b0) begin
         n_fail++; $display("FAIL score_lo: got %b want 0", score_pulse);
      end
   endtask

   task automatic test_fast();
      int n = 0;
      fast = 1; pat_valid = 0;
      while (pat_ready !== 1'b1 && n < 1000) begin
         step(); n++;
      end
      n = 0;
      step();
      n = 1;
      while (pat_ready !== 1'b1 && n < 400) begin
         step(); n++;
      end
      n_checks++;
      if (n != 128) begin
         n_fail++; $display("FAIL fast_spacing: got %0d want 128", n);
      end
      fast = 0;
      n = 0;
      while (m_cnt != 200 && n < 300) begin
         step(); n++;
      end
      n_checks++;
      if (dut.u_tick.div_cnt !== 8'd200) begin
         n_fail++;
         $display("FAIL div200: got %0d want 200", dut.u_tick.div_cnt);
      end
      fast = 1;
      step();
      n_checks++;
      if (dut.u_tick.div_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL div_wrap: got %0d want 0", dut.u_tick.div_cnt);
      end
   endtask

   task automatic fill();
      int n = 0;
      pat_valid = 1; new_pattern = 8'hA5;
      while (m_frame == '0 && n < 10) begin
         wait_tick("fill");
         step(); n++;
      end
   endtask

   task automatic test_clear();
      fill();
      bird_row = 8'hFF; active = 0;
      step();
      n_checks++;
      if (frame !== '0 || score_pulse !== 1'b0 || collide !== 1'b0) begin
         n_fail++;
         $display("FAIL active_clear: got %h/%b/%b want 0/0/0",
                  frame, score_pulse, collide);
      end
      active = 1;
      fill();
      reset = 0;
      step();
      n_checks++;
      if (frame !== '0 || score_pulse !== 1'b0 || collide !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_clear: got %h/%b/%b want 0/0/0",
                  frame, score_pulse, collide);
      end
      reset = 1;
   endtask

   task automatic test_random();
      int bad = 0;
      for (int i = 0; i < 3000; i++) begin
         pat_valid = 1'($urandom_range(0, 1));
         new_pattern = 8'($urandom);
         bird_row = 8'(1 << $urandom_range(0, ROWS - 1));
         if ($urandom_range(0, 249) == 0) fast = ~fast;
         if ($urandom_range(0, 299) == 0) gameover = ~gameover;
         active = ($urandom_range(0, 399) != 0);
         #1;
         n_checks++;
         if (frame !== m_frame || pat_ready !== m_ready() ||
             collide !== m_collide() || score_pulse !== m_score) begin
            n_fail++;
            if (bad < 10)
               $display("FAIL rand%0d: got %h %b%b%b want %h %b%b%b", i,
                        frame, pat_ready, collide, score_pulse,
                        m_frame, m_ready(), m_collide(), m_score);
            bad++;
         end
         step();
      end
   endtask

   initial begin
      test_reset();
      test_first_pipe();
      test_no_valid();
      test_collide_freeze();
      test_score();
      test_fast();
      test_clear();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
